image_capture: RTL and testbench
================================

// Module: image_capture
// PURPOSE
//   Upstream feed stage for the classifier. Accepts a raster stream of grayscale
//   pixels and binarizes each one against a threshold. Assembles the bits into a
//   LENGTH x WIDTH frame and publishes it on a double-buffered image output.
//   Pulses init_out for one cycle per completed frame; init_out drives classifier.init_in.
// PARAMETERS
//   LENGTH  32  rows per frame (image first index)
//   WIDTH   32  columns per frame (image second index), <= 32
//   PIX_W   8   grayscale pixel width
// PORTS
//   clk          in   1               clock
//   rst          in   1               synchronous active-high reset
//   threshold    in   PIX_W           binarize level, sampled on every accepted pixel
//   pix_valid    in   1               pixel present
//   pix_ready    out  1               stage can accept pixel
//   pix_sof      in   1               pixel is row 0 / col 0 of a frame
//   pix_data     in   PIX_W           grayscale pixel
//   image        out  LENGTH*WIDTH    packed [LENGTH-1:0][WIDTH-1:0], last complete frame
//   init_out     out  1               1-cycle pulse: image just updated
//   frame_count  out  16              completed frames, wraps at 2^16
//   err_count    out  8               aborted frames, saturates at 255
// BEHAVIOUR
//   - Accept = pix_valid & pix_ready. Bit = (pix_data >= threshold), unsigned compare.
//   - Raster order: col increments first; at col==WIDTH-1, col->0 and row increments.
//   - Bit written to work_buf[row][col]. work_buf is internal and separate from image.
//   - FSM states: IDLE, CAPTURE, COMMIT.
//   - IDLE: pix_ready=1. Accepted pixel with pix_sof=1 is stored at (0,0); go to CAPTURE
//     with col=1. Accepted pixel with pix_sof=0 is discarded; no counter changes.
//   - CAPTURE: pix_ready=1. Each accept stores the bit and advances the position.
//     If the accept is at (LENGTH-1, WIDTH-1), store it and go to COMMIT.
//   - CAPTURE, accepted pixel with pix_sof=1 (frame restart):
//     err_count++ (saturating); work_buf is not cleared.
//     That pixel is stored at (0,0), col=1, and the FSM stays in CAPTURE.
//   - COMMIT lasts exactly one cycle with pix_ready=0.
//     image <= work_buf; frame_count++; go to IDLE.
//     init_out=1 in the cycle after COMMIT, i.e. the cycle in which the new image
//     is first visible.
//   - Latency: last pixel accepted at cycle N gives image valid and init_out=1 at N+2.
//   - image stays stable between commits; a new frame captures in work_buf concurrently.
//   - Reset: state=IDLE, row=col=0, image=0, work_buf=0, init_out=0, frame_count=0,
//     err_count=0, pix_ready=0 during the reset cycle.
//     Reset mid-frame discards the partial frame without counting an error.
//   - pix_valid=0 gaps of any length in CAPTURE are allowed; position is held.
//   - threshold may change mid-frame; each pixel uses the value present at its accept.
// TESTING
//   - Uniform frame: pix=0x80, thr=0x80 -> image all ones, init_out 1 cycle at N+2,
//     frame_count=1.
//   - Checkerboard: pix=(r+c)&1 ? 0xFF:0x00, thr=0x10 -> image[r][c]=(r+c)&1.
//     Spot-check image[0][0]=0, image[0][1]=1, image[31][31]=0.
//   - Restart: sof again after 100 pixels, then a full frame -> err_count=1,
//     frame_count=1, image equals the second frame.
//   - Leading junk: 5 pixels with sof=0 in IDLE, then a frame -> junk ignored,
//     err_count=0, frame correct.
//   - Back-to-back frames with valid always 1 -> pix_ready low exactly 1 cycle per frame.
//     Two init_out pulses; image holds frame1 until frame2 commits.
//   - Reset at row 10 -> image=0, counts=0; next full frame captures correctly.

Source files
------------

// File: rtl/image_capture.sv
// Binarizing frame grabber: thresholds a raster pixel stream into a LENGTH x WIDTH
// bit frame and publishes each completed frame on a double-buffered image output.
module image_capture #(
  parameter int LENGTH = 32,
  parameter int WIDTH  = 32,
  parameter int PIX_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIX_W-1:0]               threshold,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic                           pix_sof,
  input  logic [PIX_W-1:0]               pix_data,
  output logic [LENGTH-1:0][WIDTH-1:0]   image,
  output logic                           init_out,
  output logic [15:0]                    frame_count,
  output logic [7:0]                     err_count
);

  localparam int ROW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [LENGTH-1:0][WIDTH-1:0] work_q, work_d;
  logic [LENGTH-1:0][WIDTH-1:0] image_q, image_d;
  logic                         init_q, init_d;
  logic [15:0]                  frame_count_q, frame_count_d;
  logic [7:0]                   err_count_q, err_count_d;

  logic                         accept;
  logic                         pix_bit;
  logic                         store;
  logic [ROW_W-1:0]             wr_row;
  logic [COL_W-1:0]             wr_col;

  assign pix_ready   = ~rst & (state_q != S_COMMIT);
  assign accept      = pix_valid & pix_ready;
  assign pix_bit     = (pix_data >= threshold);
  // A start-of-frame pixel always lands at (0,0), whatever position was reached.
  assign wr_row      = pix_sof ? '0 : row_q;
  assign wr_col      = pix_sof ? '0 : col_q;

  assign image       = image_q;
  assign init_out    = init_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    work_d        = work_q;
    image_d       = image_q;
    init_d        = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    store         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && pix_sof) store = 1'b1;
      end
      S_CAPTURE: begin
        if (accept) begin
          store = 1'b1;
          if (pix_sof && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        end
      end
      S_COMMIT: begin
        image_d       = work_q;
        frame_count_d = frame_count_q + 16'd1;
        init_d        = 1'b1;
        state_d       = S_IDLE;
        row_d         = '0;
        col_d         = '0;
      end
      default: begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    if (store) begin
      work_d[wr_row][wr_col] = pix_bit;
      if ((wr_row == LAST_ROW) && (wr_col == LAST_COL)) begin
        state_d = S_COMMIT;
        row_d   = '0;
        col_d   = '0;
      end else begin
        state_d = S_CAPTURE;
        if (wr_col == LAST_COL) begin
          col_d = '0;
          row_d = wr_row + ROW_W'(1);
        end else begin
          col_d = wr_col + COL_W'(1);
          row_d = wr_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      work_q        <= '0;
      image_q       <= '0;
      init_q        <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      work_q        <= work_d;
      image_q       <= image_d;
      init_q        <= init_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_image_capture.sv
// Directed bench for image_capture: table-driven threshold vectors plus
// hand-written sequences for commit latency, restart, junk, back-to-back and reset.
module tb_image_capture;

  typedef logic [31:0][31:0] img_t;
  typedef struct {
    logic [7:0] pix;
    logic [7:0] thr;
    logic       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  threshold = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = '0;
  img_t        image;
  logic        init_out;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  vec_t tbl[8];

  logic mon_en = 1'b0;
  int   mon_lo = 0;
  int   mon_init = 0;

  image_capture #(.LENGTH(32), .WIDTH(32), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .threshold(threshold), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
    .image(image), .init_out(init_out), .frame_count(frame_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!pix_ready) mon_lo++;
      if (init_out) mon_init++;
    end
  end

  function automatic logic [7:0] pix_of(int kind, int r, int c);
    case (kind)
      0: return 8'h80;
      1: return ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
      2: return tbl[(r * 32 + c) % 8].pix;
      3: return 8'(r * 7 + c * 13);
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] thr_of(int kind, int r, int c);
    case (kind)
      0: return 8'h80;
      1: return 8'h10;
      2: return tbl[(r * 32 + c) % 8].thr;
      3: return 8'(r * 8);
      default: return 8'h00;
    endcase
  endfunction

  function automatic img_t model(int kind);
    img_t m;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        m[r][c] = (kind == 2) ? tbl[(r * 32 + c) % 8].exp
                              : (pix_of(kind, r, c) >= thr_of(kind, r, c));
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input img_t exp);
    int bad = 0;
    int first = -1;
    checks++;
    for (int k = 0; k < 1024; k++)
      if (image[k / 32][k % 32] !== exp[k / 32][k % 32]) begin
        bad++;
        if (first < 0) first = k;
      end
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bits differ, first at row %0d col %0d got %b expected %b",
               name, bad, first / 32, first % 32,
               image[first / 32][first % 32], exp[first / 32][first % 32]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] pix, input logic [7:0] thr, input logic sof);
    int waits = 0;
    pix_data  = pix;
    threshold = thr;
    pix_sof   = sof;
    pix_valid = 1'b1;
    while (!pix_ready && waits < 20) begin
      step();
      waits++;
    end
    if (waits >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got pix_ready 0 expected 1 within 20 cycles");
    end
    step();
  endtask

  task automatic send_range(input int kind, input int first, input int n, input bit gaps);
    for (int k = first; k < first + n; k++) begin
      send_pixel(pix_of(kind, k / 32, k % 32), thr_of(kind, k / 32, k % 32), k == 0);
      if (gaps && (k % 37 == 36)) begin
        pix_valid = 1'b0;
        repeat (3) step();
      end
    end
  endtask

  // Drop valid and move to the cycle in which the committed image is first visible.
  task automatic finish_frame();
    pix_valid = 1'b0;
    step();
  endtask

  initial begin
    tbl[0] = '{pix: 8'h80, thr: 8'h80, exp: 1'b1};
    tbl[1] = '{pix: 8'h7F, thr: 8'h80, exp: 1'b0};
    tbl[2] = '{pix: 8'h00, thr: 8'h00, exp: 1'b1};
    tbl[3] = '{pix: 8'hFF, thr: 8'hFF, exp: 1'b1};
    tbl[4] = '{pix: 8'hFE, thr: 8'hFF, exp: 1'b0};
    tbl[5] = '{pix: 8'h01, thr: 8'h00, exp: 1'b1};
    tbl[6] = '{pix: 8'h00, thr: 8'h01, exp: 1'b0};
    tbl[7] = '{pix: 8'hFF, thr: 8'h80, exp: 1'b1};

    // Reset state
    rst = 1'b1;
    step();
    chk("ready_in_reset", 32'(pix_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk_img("reset_image", '0);
    chk("reset_init", 32'(init_out), 32'd0);
    chk("reset_frame_count", 32'(frame_count), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("ready_after_reset", 32'(pix_ready), 32'd1);

    // Uniform frame with commit latency
    send_range(0, 0, 1024, 1'b0);
    pix_valid = 1'b0;
    chk("commit_ready_low", 32'(pix_ready), 32'd0);
    chk("commit_init_early", 32'(init_out), 32'd0);
    chk_img("commit_image_old", '0);
    step();
    chk("uniform_init", 32'(init_out), 32'd1);
    chk_img("uniform_image", model(0));
    chk("uniform_frame_count", 32'(frame_count), 32'd1);
    step();
    chk("uniform_init_1cycle", 32'(init_out), 32'd0);

    // Checkerboard
    send_range(1, 0, 1024, 1'b0);
    finish_frame();
    chk("checker_00", 32'(image[0][0]), 32'd0);
    chk("checker_01", 32'(image[0][1]), 32'd1);
    chk("checker_3131", 32'(image[31][31]), 32'd0);
    chk_img("checker_image", model(1));
    chk("checker_frame_count", 32'(frame_count), 32'd2);

    // Restart after 100 pixels
    do_reset();
    send_range(4, 0, 100, 1'b0);
    send_range(3, 0, 1024, 1'b0);
    finish_frame();
    chk("restart_err_count", 32'(err_count), 32'd1);
    chk("restart_frame_count", 32'(frame_count), 32'd1);
    chk_img("restart_image", model(3));

    // Leading junk, then a table-driven frame with valid gaps
    do_reset();
    for (int i = 0; i < 5; i++) send_pixel(8'hFF, 8'h00, 1'b0);
    pix_valid = 1'b0;
    step();
    chk("junk_ready", 32'(pix_ready), 32'd1);
    chk("junk_frame_count", 32'(frame_count), 32'd0);
    chk("junk_err_count", 32'(err_count), 32'd0);
    chk_img("junk_image", '0);
    send_range(2, 0, 1024, 1'b1);
    finish_frame();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("table_row0_%0d", i), 32'(image[0][i]), 32'(tbl[i].exp));
      chk($sformatf("table_row31_%0d", i), 32'(image[31][24 + i]), 32'(tbl[i].exp));
    end
    chk_img("table_image", model(2));
    chk("table_frame_count", 32'(frame_count), 32'd1);
    chk("table_err_count", 32'(err_count), 32'd0);

    // Back-to-back frames with valid held high
    do_reset();
    mon_lo = 0;
    mon_init = 0;
    mon_en = 1'b1;
    send_range(1, 0, 1024, 1'b0);
    send_range(3, 0, 500, 1'b0);
    chk_img("b2b_hold_frame1", model(1));
    chk("b2b_mid_inits", 32'(mon_init), 32'd1);
    send_range(3, 500, 524, 1'b0);
    finish_frame();
    chk_img("b2b_frame2", model(3));
    step();
    mon_en = 1'b0;
    chk("b2b_ready_low_cycles", 32'(mon_lo), 32'd2);
    chk("b2b_init_pulses", 32'(mon_init), 32'd2);
    chk("b2b_frame_count", 32'(frame_count), 32'd2);

    // Reset in the middle of row 10
    send_range(4, 0, 10 * 32 + 5, 1'b0);
    do_reset();
    chk_img("midreset_image", '0);
    chk("midreset_frame_count", 32'(frame_count), 32'd0);
    chk("midreset_err_count", 32'(err_count), 32'd0);
    send_range(3, 0, 1024, 1'b0);
    finish_frame();
    chk_img("postreset_image", model(3));
    chk("postreset_frame_count", 32'(frame_count), 32'd1);
    chk("postreset_err_count", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
